dlatch_pack: RTL

//   Parametrised successor of the dlatch register: collects Ratio words of

---
 rtl/dlatch_pkg.sv | 16 +
 rtl/dlatch_pack.sv | 76 +++++++
 2 files changed

// File: rtl/dlatch_pkg.sv
// Shared definitions for the dlatch packer: default pad value, slot ordering
// and the slot decode used to place each incoming word.
package dlatch_pkg;

  localparam logic [31:0] DLATCH_INIT = 32'hDEADBEEF;

  typedef enum logic {LSB_FIRST, MSB_FIRST} slot_order_t;

  // Word k of a packet lands in slot k, or mirrored when MSB-first.
  function automatic int unsigned slot_idx(input int unsigned count,
                                           input int unsigned ratio,
                                           input slot_order_t   order);
    return (order == MSB_FIRST) ? (ratio - 1 - count) : count;
  endfunction

endpackage

// File: rtl/dlatch_pack.sv
// Packs Ratio narrow words into one wide word behind a valid/ready handshake,
// with selectable slot order and partial-packet flush padded from Init.
module dlatch_pack
  import dlatch_pkg::*;
#(
  parameter int                       InWidth  = 16,
  parameter int                       Ratio    = 2,
  parameter logic [InWidth*Ratio-1:0] Init     = DLATCH_INIT,
  parameter bit                       MsbFirst = 1'b0
) (
  input  logic                       Clk_i,
  input  logic                       Reset_i,
  input  logic                       Wen_i,
  input  logic [InWidth-1:0]         Data_i,
  input  logic                       Flush_i,
  output logic                       Ready_o,
  output logic                       Valid_o,
  input  logic                       Ready_i,
  output logic [InWidth*Ratio-1:0]   Data_o,
  output logic [$clog2(Ratio+1)-1:0] Count_o
);

  localparam int          W       = InWidth * Ratio;
  localparam int          CW      = $clog2(Ratio + 1);
  localparam logic [CW-1:0] LAST  = CW'(Ratio - 1);
  localparam slot_order_t ORDER   = MsbFirst ? MSB_FIRST : LSB_FIRST;
  localparam bit          FLUSHEN = (Ratio > 1);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;
  logic          r_valid;

  logic          w_acc;
  logic          w_last;
  logic          w_flush;
  logic          w_done;
  int unsigned   w_slot;
  logic [W-1:0]  w_next;

  assign Ready_o = !Reset_i && (!r_valid || Ready_i);
  assign w_acc   = Wen_i && Ready_o;
  assign w_last  = w_acc && (r_count == LAST);
  // A word written alongside the flush counts toward a non-empty packet.
  assign w_flush = FLUSHEN && Flush_i && Ready_o && ((r_count != '0) || w_acc);
  assign w_done  = w_last || w_flush;
  assign w_slot  = slot_idx(int'(r_count), Ratio, ORDER);

  always_comb begin
    w_next = (r_count == '0) ? Init : r_data;
    w_next[w_slot*InWidth +: InWidth] = Data_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_data  <= Init;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_acc)
        r_data <= w_next;
      if (w_done)
        r_count <= '0;
      else if (w_acc)
        r_count <= r_count + CW'(1);
      if (w_done)
        r_valid <= 1'b1;
      else if (Ready_i)
        r_valid <= 1'b0;
    end
  end

  assign Valid_o = r_valid;
  assign Data_o  = r_data;
  assign Count_o = r_count;

endmodule
